// File: rtl/seq_approx_mult_pkg.sv
// Shared types and constants for the sequential nibble-serial approximate multiplier.
package seq_approx_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIB_W = 4;

  function automatic int nib_count(input int w);
    return w / NIB_W;
  endfunction

endpackage

// File: rtl/seq_approx_mult_nibble_mul4.sv
// 4x4 multiply kernel; the approximate mode drops the LSB of both nibbles.
module nibble_mul4
  import seq_approx_mult_pkg::*;
(
  input  logic [NIB_W-1:0] a4,
  input  logic [NIB_W-1:0] b4,
  input  logic             approx,
  output logic [7:0]       p
);

  logic [NIB_W-1:0] a_k;
  logic [NIB_W-1:0] b_k;

  always_comb begin
    a_k = approx ? (a4 & 4'b1110) : a4;
    b_k = approx ? (b4 & 4'b1110) : b4;
    p   = {4'b0000, a_k} * {4'b0000, b_k};
  end

endmodule

// File: rtl/seq_approx_mult.sv
// Sequential multiplier: one nibble partial product per cycle, low-significance
// products optionally approximated, accumulated by add or by OR.
module seq_approx_mult
  import seq_approx_mult_pkg::*;
#(
  parameter int W      = 8,
  parameter int THRESH = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           acc_or,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] r
);

  localparam int K     = nib_count(W);
  localparam int NPP   = K * K;
  localparam int CNT_W = (NPP > 1) ? $clog2(NPP) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NPP - 1);

  if (W < 4 || W > 32 || (W % 4) != 0) begin : g_bad_w
    $error("seq_approx_mult: W must be a multiple of 4 in 4..32");
  end

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic             acc_or_q, acc_or_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  int               idx_i;
  int               idx_j;
  logic [NIB_W-1:0] a_nib;
  logic [NIB_W-1:0] b_nib;
  logic             approx;
  logic [7:0]       pp;
  logic [2*W-1:0]   pp_shift;

  // j (b nibble) is the outer index, i (a nibble) the inner one.
  always_comb begin
    idx_i  = int'(cnt_q) % K;
    idx_j  = int'(cnt_q) / K;
    a_nib  = NIB_W'(a_q >> (NIB_W * idx_i));
    b_nib  = NIB_W'(b_q >> (NIB_W * idx_j));
    approx = (idx_i + idx_j) < THRESH;
  end

  nibble_mul4 u_kernel (
    .a4     (a_nib),
    .b4     (b_nib),
    .approx (approx),
    .p      (pp)
  );

  assign pp_shift = (2 * W)'(pp) << (NIB_W * (idx_i + idx_j));

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_or_d = acc_or_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_ready_q && in_valid) begin
          a_d      = a;
          b_d      = b;
          acc_or_d = acc_or;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        acc_d = acc_or_q ? (acc_q | pp_shift) : (acc_q + pp_shift);
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Handshake outputs are registered decodes of the next state.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_or_q    <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_or_q    <= acc_or_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign r         = acc_q;

endmodule

// File: tb/tb_seq_approx_mult.sv
// Directed and random checks of seq_approx_mult at W=8 (THRESH 0 and 1) and W=16.
module tb_seq_approx_mult;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  in_valid;
  logic [2:0]  in_ready;
  logic [2:0]  out_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        acc_or;
  logic        out_ready;
  logic [15:0] r0;
  logic [15:0] r1;
  logic [31:0] r2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_approx_mult #(.W(8), .THRESH(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a[7:0]), .b(b[7:0]), .acc_or(acc_or), .out_valid(out_valid[0]),
    .out_ready(out_ready), .r(r0)
  );

  seq_approx_mult #(.W(8), .THRESH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a[7:0]), .b(b[7:0]), .acc_or(acc_or), .out_valid(out_valid[1]),
    .out_ready(out_ready), .r(r1)
  );

  seq_approx_mult #(.W(16), .THRESH(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a), .b(b), .acc_or(acc_or), .out_valid(out_valid[2]),
    .out_ready(out_ready), .r(r2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] get_r(input int sel);
    case (sel)
      0:       return {16'h0, r0};
      1:       return {16'h0, r1};
      default: return r2;
    endcase
  endfunction

  // Result is X when out_valid never rose, so any timeout fails the result check.
  task automatic txn(input int sel, input logic [15:0] aa, input logic [15:0] bb,
                     input logic orr, output logic [31:0] res, output int lat);
    int n;
    n = 0;
    while (!in_ready[sel] && n < 50) begin
      tick();
      n++;
    end
    a = aa;
    b = bb;
    acc_or = orr;
    in_valid[sel] = 1'b1;
    tick();
    in_valid[sel] = 1'b0;
    lat = 0;
    while (!out_valid[sel] && lat < 100) begin
      tick();
      lat++;
    end
    res = out_valid[sel] ? get_r(sel) : 'x;
    $display("txn dut%0d a=%0d b=%0d or=%0d r=%0d lat=%0d", sel, aa, bb, orr, res, lat);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] res;
    logic [31:0] exp;
    logic [15:0] ra;
    logic [15:0] rb;
    int lat;
    int cyc;
    int got;
    int seen;
    int rise_cyc [4];

    rst_n = 1'b0;
    in_valid = 3'b000;
    a = '0;
    b = '0;
    acc_or = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) rise_cyc[k] = 0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 64'(in_ready), 64'(3'b000));
    check("reset_out_valid", 64'(out_valid), 64'(3'b000));
    check("reset_r0", 64'(r0), 64'd0);
    check("reset_r2", 64'(r2), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("in_ready_after_reset", 64'(in_ready), 64'(3'b111));

    txn(0, 16'd200, 16'd150, 1'b0, res, lat);
    check("exact_200x150", 64'(res), 64'd30000);
    check("latency_w8", 64'(lat), 64'd4);

    txn(1, 16'h000F, 16'h000F, 1'b0, res, lat);
    check("approx_0f_0f", 64'(res), 64'd196);

    txn(0, 16'h0011, 16'h0011, 1'b1, res, lat);
    check("or_11_11", 64'(res), 64'd273);

    txn(1, 16'h00FF, 16'h00FF, 1'b0, res, lat);
    check("approx_ff_ff_add", 64'(res), 64'd64996);

    txn(1, 16'h00FF, 16'h00FF, 1'b1, res, lat);
    check("approx_ff_ff_or", 64'(res), 64'd61396);

    out_ready = 1'b0;
    txn(0, 16'd13, 16'd7, 1'b0, res, lat);
    check("hold_result", 64'(res), 64'd91);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("hold_out_valid", 64'(out_valid[0]), 64'd1);
      check("hold_r", 64'(r0), 64'd91);
      check("hold_in_ready", 64'(in_ready[0]), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    check("release_out_valid", 64'(out_valid[0]), 64'd0);
    check("release_in_ready", 64'(in_ready[0]), 64'd1);

    // Back-to-back at W=16 with in_valid held high.
    a = 16'h1234;
    b = 16'h5678;
    acc_or = 1'b0;
    exp = 32'(16'h1234) * 32'(16'h5678);
    in_valid[2] = 1'b1;
    cyc = 0;
    got = 0;
    while (got < 4 && cyc < 200) begin
      tick();
      cyc++;
      if (out_valid[2]) begin
        rise_cyc[got] = cyc;
        check("b2b_r", 64'(r2), 64'(exp));
        $display("b2b result %0d at cycle %0d r=%0d", got, cyc, r2);
        got++;
      end
    end
    in_valid[2] = 1'b0;
    check("b2b_count", 64'(got), 64'd4);
    for (int k = 1; k < 4; k++)
      check("b2b_period", 64'(rise_cyc[k] - rise_cyc[k-1]), 64'd18);

    // Reset during the second CALC cycle discards the transaction.
    tick();
    tick();
    a = 16'd200;
    b = 16'd150;
    in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_reset_out_valid", 64'(out_valid[0]), 64'd0);
    check("mid_reset_r", 64'(r0), 64'd0);
    check("mid_reset_in_ready", 64'(in_ready[0]), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("mid_reset_ready_after", 64'(in_ready[0]), 64'd1);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (out_valid[0]) seen++;
    end
    check("mid_reset_no_stale", 64'(seen), 64'd0);
    $display("reset-in-CALC stale out_valid count=%0d", seen);

    for (int k = 0; k < 1000; k++) begin
      if (k == 0) begin
        ra = 16'hFFFF;
        rb = 16'hFFFF;
      end else if (k == 1) begin
        ra = 16'h0000;
        rb = 16'hFFFF;
      end else begin
        ra = 16'($urandom);
        rb = 16'($urandom);
      end
      txn(2, ra, rb, 1'b0, res, lat);
      exp = 32'(ra) * 32'(rb);
      check("rand_exact_w16", 64'(res), 64'(exp));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
